// File: rtl/kbd_report_parser_pkg.sv
// Shared keyboard types and keycode constants for the report parser and movement logic.
package kbd_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_t;

    localparam logic [7:0] KEY_NONE         = 8'h00;
    localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
    localparam logic [7:0] KEY_ERR_LAST     = 8'h03;
    localparam logic [7:0] KEY_FIRST_VALID  = 8'h04;
    localparam logic [7:0] KEY_W            = 8'h1A;
    localparam logic [7:0] KEY_D            = 8'h07;

    // 01..03 are the HID phantom/rollover/POST-fail codes, not real keys
    function automatic logic is_err_key(input logic [7:0] k);
        return (k >= KEY_ERR_ROLLOVER) && (k <= KEY_ERR_LAST);
    endfunction

endpackage

// File: rtl/kbd_report_parser_if.sv
// Report byte stream in, decoded keycodes out. err_count exists only with KBD_ERR_CNT_EN.
interface kbd_report_parser_if;

    logic [7:0] rpt_byte;
    logic       rpt_valid;
    logic       rpt_sof;
    logic       rpt_ready;
    logic [7:0] keycode;
    logic [7:0] keycode1;
    logic [7:0] modifier;
    logic       report_strobe;
`ifdef KBD_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    modport master (
        output rpt_byte, rpt_valid, rpt_sof,
`ifdef KBD_ERR_CNT_EN
        input  err_count,
`endif
        input  rpt_ready, keycode, keycode1, modifier, report_strobe
    );

    modport slave (
        input  rpt_byte, rpt_valid, rpt_sof,
`ifdef KBD_ERR_CNT_EN
        output err_count,
`endif
        output rpt_ready, keycode, keycode1, modifier, report_strobe
    );

endinterface

// File: rtl/kbd_report_parser_watchdog.sv
// Free-running silence counter; expire pulses when it reaches TIMEOUT_CYCLES-1 (needs >= 2).
module kbd_watchdog #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expire = (cnt == LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            cnt <= '0;
        else if (clear || expire)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/kbd_report_parser.sv
// HID boot-keyboard report parser: collects 8-byte reports, publishes first two distinct keys.
// Optional saturating error counter enabled by defining KBD_ERR_CNT_EN.
module kbd_report_parser
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int RPT_BYTES      = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    kbd_report_parser_if.slave bus
);

    localparam int IW = $clog2(RPT_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(RPT_BYTES - 1);

    state_t                    state, state_nxt;
    logic [IW-1:0]             idx;
    logic [RPT_BYTES-1:0][7:0] rbuf;
    logic                      ready, accept, publish, expire, rpt_err;
    logic [7:0]                k0, k1;
    logic [7:0]                modifier_q, keycode_q, keycode1_q;
    logic                      strobe_q;

    assign accept  = bus.rpt_valid & ready;
    assign publish = (state == PUBLISH);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b1;
        case (state)
            IDLE:    if (accept && bus.rpt_sof) state_nxt = COLLECT;
            COLLECT: if (accept && !bus.rpt_sof && idx == LAST_IDX) state_nxt = PUBLISH;
            PUBLISH: begin
                ready     = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // sof always restarts the buffer, whether idle or mid-report
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx  <= '0;
            rbuf <= '0;
        end else if (accept) begin
            if (bus.rpt_sof) begin
                rbuf[0] <= bus.rpt_byte;
                idx     <= IW'(1);
            end else if (state == COLLECT) begin
                rbuf[idx] <= bus.rpt_byte;
                idx       <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
            end
        end
    end

    always_comb begin
        k0      = KEY_NONE;
        k1      = KEY_NONE;
        rpt_err = 1'b0;
        for (int i = 2; i < RPT_BYTES; i++) begin
            if (is_err_key(rbuf[i])) rpt_err = 1'b1;
            if (rbuf[i] >= KEY_FIRST_VALID) begin
                if (k0 == KEY_NONE)
                    k0 = rbuf[i];
                else if (k1 == KEY_NONE && rbuf[i] != k0)
                    k1 = rbuf[i];
            end
        end
    end

    kbd_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clear   (publish),
        .expire  (expire)
    );

    // publish takes priority over a coinciding timeout
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            modifier_q <= '0;
            keycode_q  <= '0;
            keycode1_q <= '0;
            strobe_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (publish) begin
                if (!rpt_err) begin
                    modifier_q <= rbuf[0];
                    keycode_q  <= k0;
                    keycode1_q <= k1;
                    strobe_q   <= ({rbuf[0], k0, k1} != {modifier_q, keycode_q, keycode1_q});
                end
            end else if (expire) begin
                modifier_q <= '0;
                keycode_q  <= '0;
                keycode1_q <= '0;
                strobe_q   <= |{modifier_q, keycode_q, keycode1_q};
            end
        end
    end

`ifdef KBD_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       err_evt;

    assign err_evt = (publish && rpt_err)
                   || (accept && state == IDLE && !bus.rpt_sof)
                   || (accept && state == COLLECT && bus.rpt_sof);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            err_cnt_q <= '0;
        else if (err_evt && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign bus.err_count = err_cnt_q;
`endif

    assign bus.rpt_ready     = ready;
    assign bus.keycode       = keycode_q;
    assign bus.keycode1      = keycode1_q;
    assign bus.modifier      = modifier_q;
    assign bus.report_strobe = strobe_q;

endmodule
